// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side control for the dual-clock async FIFO.
// Keeps the binary and Gray write pointers and brings the read pointer into
// wclk through a 2-flop synchronizer. From those it produces the full and
// almost-full flags and the write-side fill level.
//
// Ports:
//   wclk          write clock; all state updates on posedge
//   wrst_n        asynchronous active-low reset
//   winc          write request; accepted only while wfull is low
//   rptr          Gray read pointer from the read domain (asynchronous)
//   waddr         memory write address (low bits of the binary write pointer)
//   wptr          registered Gray write pointer to the read domain
//   wfull         registered full flag
//   walmost_full  registered almost-full flag (fill >= DEPTH-ALMOST_FULL_MARGIN)
//   wfill         occupancy seen from the write side, 0..DEPTH
//   woverflow     sticky dropped-write flag
//
// Optional feature: define WPTR_OVERFLOW_DETECT_EN to build the sticky
// woverflow register. When the macro is undefined, woverflow is tied low.
module fifo_wptr_full #(
    parameter int unsigned ADDRESS_SIZE       = 4,
    parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    winc,
    input  logic [ADDRESS_SIZE:0]   rptr,
    output logic [ADDRESS_SIZE-1:0] waddr,
    output logic [ADDRESS_SIZE:0]   wptr,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [ADDRESS_SIZE:0]   wfill,
    output logic                    woverflow
);

    localparam int unsigned PTR_W    = ADDRESS_SIZE + 1;
    localparam int unsigned DEPTH    = 32'd1 << ADDRESS_SIZE;
    localparam int unsigned AF_INT   = DEPTH - ALMOST_FULL_MARGIN;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_INT);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] rq1;
    logic [PTR_W-1:0] rq2;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] wbinnext;
    logic [PTR_W-1:0] wgraynext;
    logic             wen;
    logic             wfull_next;
    logic             walmost_full_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b = g;
        for (int unsigned k = 1; k < PTR_W; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

    // Next pointer and flag values; rptr reaches these only through rq1/rq2
    always_comb begin
        wen               = winc & ~wfull;
        rbin_s            = gray2bin(rq2);
        wbinnext          = wbin + PTR_W'(wen);
        wgraynext         = (wbinnext >> 1) ^ wbinnext;
        // Full when the write pointer is one lap ahead: top two Gray bits inverted
        wfull_next        = (wgraynext == {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]});
        walmost_full_next = ((wbinnext - rbin_s) >= AF_LEVEL);
    end

    // Pointer, synchronizer and flag registers
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            rq1          <= '0;
            rq2          <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            rq1          <= rptr;
            rq2          <= rq1;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
        end
    end

    // Address and fill come straight from registers; fill lags reads by the sync delay
    assign waddr = wbin[ADDRESS_SIZE-1:0];
    assign wfill = wbin - rbin_s;

`ifdef WPTR_OVERFLOW_DETECT_EN
    // Sticky record of any write attempted while full
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end
    end
`else
    assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed checks of fifo_wptr_full with ADDRESS_SIZE=4 and
// ALMOST_FULL_MARGIN=2. Inputs are driven on the falling edge, and outputs are
// sampled 1 time unit after the rising edge.
module tb_fifo_wptr_full;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wfill;
    logic       woverflow;

    int vec;
    int errs;

`ifdef WPTR_OVERFLOW_DETECT_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    fifo_wptr_full #(
        .ADDRESS_SIZE       (4),
        .ALMOST_FULL_MARGIN (2)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr         (rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wfill        (wfill),
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [4:0] bin2gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Stimulus only: reset pulse, then n writes against rptr=0
    task automatic do_reset_and_fill(input int n);
        @(negedge wclk);
        winc   = 1'b0;
        rptr   = 5'd0;
        wrst_n = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge wclk);
            winc = 1'b1;
        end
        @(negedge wclk);
        winc = 1'b0;
    endtask

    task automatic test_reset;
        wrst_n = 1'b0;
        winc   = 1'b1;
        rptr   = 5'b10101;
        #1;
        vec++;
        if ({waddr, wptr, wfull, walmost_full, wfill, woverflow} !== 17'd0) begin
            errs++;
            $display("FAIL reset_immediate: got %h expected 0",
                     {waddr, wptr, wfull, walmost_full, wfill, woverflow});
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge wclk);
            #1;
            vec++;
            if ({waddr, wptr, wfull, walmost_full, wfill, woverflow} !== 17'd0) begin
                errs++;
                $display("FAIL reset_held cycle %0d: got %h expected 0", c,
                         {waddr, wptr, wfull, walmost_full, wfill, woverflow});
            end
        end
        @(negedge wclk);
        winc   = 1'b0;
        rptr   = 5'd0;
        wrst_n = 1'b1;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            @(negedge wclk);
            winc = 1'b1;
            #1;
            vec++;
            if (waddr !== 4'(i)) begin
                errs++;
                $display("FAIL fill_waddr %0d: got %0d expected %0d", i, waddr, i);
            end
            @(posedge wclk);
            #1;
            vec++;
            if (wfill !== 5'(i + 1)) begin
                errs++;
                $display("FAIL fill_wfill %0d: got %0d expected %0d", i, wfill, i + 1);
            end
            vec++;
            if (walmost_full !== (i + 1 >= 14)) begin
                errs++;
                $display("FAIL fill_walmost %0d: got %b expected %b", i, walmost_full, (i + 1 >= 14));
            end
            vec++;
            if (wfull !== (i + 1 == 16)) begin
                errs++;
                $display("FAIL fill_wfull %0d: got %b expected %b", i, wfull, (i + 1 == 16));
            end
        end
        @(negedge wclk);
        winc = 1'b0;
        vec++;
        if ({wptr, waddr, wfill} !== {5'b11000, 4'd0, 5'd16}) begin
            errs++;
            $display("FAIL fill_final: wptr=%b waddr=%0d wfill=%0d expected 11000/0/16",
                     wptr, waddr, wfill);
        end
    endtask

    task automatic test_overflow;
        for (int c = 0; c < 3; c++) begin
            @(negedge wclk);
            winc = 1'b1;
            @(posedge wclk);
            #1;
            vec++;
            if ({wptr, wfull, wfill} !== {5'b11000, 1'b1, 5'd16}) begin
                errs++;
                $display("FAIL ovf_hold %0d: wptr=%b wfull=%b wfill=%0d expected 11000/1/16",
                         c, wptr, wfull, wfill);
            end
            vec++;
            if (woverflow !== EXP_OVF) begin
                errs++;
                $display("FAIL ovf_flag %0d: got %b expected %b", c, woverflow, EXP_OVF);
            end
        end
        @(negedge wclk);
        winc = 1'b0;
    endtask

    task automatic test_release;
        @(negedge wclk);
        rptr = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            @(posedge wclk);
            #1;
            vec++;
            if (wfull !== (e < 3)) begin
                errs++;
                $display("FAIL release_wfull edge %0d: got %b expected %b", e, wfull, (e < 3));
            end
            vec++;
            if (walmost_full !== 1'b1) begin
                errs++;
                $display("FAIL release_walmost edge %0d: got %b expected 1", e, walmost_full);
            end
        end
        vec++;
        if (wfill !== 5'd15) begin
            errs++;
            $display("FAIL release_wfill: got %0d expected 15", wfill);
        end
    endtask

    task automatic test_wrap;
        logic [4:0] wb;
        logic [4:0] rb;
        logic [4:0] prev;
        logic       saw_wrap;
        do_reset_and_fill(4);
        wb = 5'd4;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        vec++;
        if (wfill !== 5'd4) begin
            errs++;
            $display("FAIL wrap_prefill: got %0d expected 4", wfill);
        end
        // Stage rptr one ahead so the 2-edge sync lag keeps the seen fill at 4
        @(negedge wclk);
        rb   = wb - 5'd3;
        rptr = bin2gray(rb);
        @(posedge wclk);
        prev     = wptr;
        saw_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge wclk);
            winc = 1'b1;
            rb   = wb - 5'd2;
            rptr = bin2gray(rb);
            @(posedge wclk);
            #1;
            wb = wb + 5'd1;
            vec++;
            if (wptr !== bin2gray(wb)) begin
                errs++;
                $display("FAIL wrap_wptr %0d: got %b expected %b", i, wptr, bin2gray(wb));
            end
            vec++;
            if ({wfull, wfill} !== {1'b0, 5'd4}) begin
                errs++;
                $display("FAIL wrap_flags %0d: wfull=%b wfill=%0d expected 0/4", i, wfull, wfill);
            end
            if (prev == 5'b10000 && wptr == 5'b00000) saw_wrap = 1'b1;
            prev = wptr;
        end
        @(negedge wclk);
        winc = 1'b0;
        vec++;
        if (saw_wrap !== 1'b1) begin
            errs++;
            $display("FAIL wrap_transition: got %b expected 1", saw_wrap);
        end
    endtask

    task automatic test_midop_reset;
        do_reset_and_fill(16);
        @(negedge wclk);
        winc = 1'b1;
        @(posedge wclk);
        #1;
        vec++;
        if ({wfull, woverflow} !== {1'b1, EXP_OVF}) begin
            errs++;
            $display("FAIL midop_pre: wfull=%b woverflow=%b expected 1/%b", wfull, woverflow, EXP_OVF);
        end
        @(negedge wclk);
        wrst_n = 1'b0;
        #1;
        vec++;
        if ({waddr, wptr, wfull, walmost_full, wfill, woverflow} !== 17'd0) begin
            errs++;
            $display("FAIL midop_reset: got %h expected 0",
                     {waddr, wptr, wfull, walmost_full, wfill, woverflow});
        end
        @(negedge wclk);
        winc   = 1'b0;
        wrst_n = 1'b1;
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
